// File: rtl/interleaver_bus_n.sv
// Block interleaver: buffers one LANES-bit word per cycle, zero-pads short blocks,
// then replays with a per-lane strided read order. Optional debug ports: INTERLEAVER_BUS_DEBUG_EN.
`timescale 1ns/1ps
module interleaver_bus_n #(
    parameter int LANES    = 8,
    parameter int DEPTH    = 64,
    parameter int STRIDE   = 5,
    parameter int OFF_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] data_in,
    input  logic             CRC_start,
    input  logic             CRC_end,
    input  logic [1:0]       mode,
    input  logic             out_ready,
    output logic [LANES-1:0] data_out,
    output logic             data_ready,
    output logic             done,
    output logic             busy,
    output logic             err
`ifdef INTERLEAVER_BUS_DEBUG_EN
    ,
    output logic [2:0]               dbg_state,
    output logic [$clog2(DEPTH)-1:0] dbg_wcnt,
    output logic [$clog2(DEPTH)-1:0] dbg_rcnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic [AW-1:0]    wcnt;
    logic [AW-1:0]    rcnt;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    waddr;
    logic [1:0]       mode_q;
    logic             we;
    logic [LANES-1:0] wdata;
    logic [LANES-1:0] rd_word;
    logic [LANES-1:0] mem [DEPTH];

    // DEPTH is a power of two, so the modulo reduces to a mask.
    function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] idx,
                                                input logic [1:0] m, input int k);
        int off;
        case (m)
            2'd1:    off = (k * OFF_STEP) % DEPTH;
            2'd2:    off = (((LANES - k) % LANES) * OFF_STEP) % DEPTH;
            default: off = 0;
        endcase
        return AW'((int'(idx) * STRIDE + off) & (DEPTH - 1));
    endfunction

    always_comb begin
        we    = 1'b0;
        waddr = wcnt;
        wdata = data_in;
        case (state)
            IDLE: begin
                we    = CRC_start;
                waddr = '0;
            end
            LOAD: begin
                we = 1'b1;
                if (CRC_start) waddr = '0;
            end
            FILL: begin
                we    = 1'b1;
                wdata = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // First DRAIN cycle fetches word 0; afterwards fetch the word after the one on the bus.
    assign rd_idx = data_ready ? rcnt + AW'(1) : '0;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < LANES; k++)
            rd_word[k] = mem[lane_addr(rd_idx, mode_q, k)][k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            rcnt       <= '0;
            mode_q     <= 2'd0;
            data_out   <= '0;
            data_ready <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (CRC_start) begin
                        mode_q <= mode;
                        wcnt   <= AW'(1);
                        state  <= CRC_end ? FILL : LOAD;
                    end
                end
                LOAD: begin
                    if (CRC_start) begin
                        err    <= 1'b1;
                        mode_q <= mode;
                        wcnt   <= AW'(1);
                    end else begin
                        wcnt <= wcnt + AW'(1);
                        if (wcnt == LAST)  state <= DRAIN;
                        else if (CRC_end)  state <= FILL;
                    end
                end
                FILL: begin
                    wcnt <= wcnt + AW'(1);
                    if (wcnt == LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (!data_ready) begin
                        data_out   <= rd_word;
                        data_ready <= 1'b1;
                        rcnt       <= '0;
                    end else if (out_ready) begin
                        if (rcnt != LAST) begin
                            data_out <= rd_word;
                            rcnt     <= rcnt + AW'(1);
                        end else begin
                            data_ready <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef INTERLEAVER_BUS_DEBUG_EN
    assign dbg_state = {1'b0, state};
    assign dbg_wcnt  = wcnt;
    assign dbg_rcnt  = rcnt;
`endif

endmodule

// File: tb/tb_interleaver_bus_n.sv
// Self-checking bench for interleaver_bus_n (LANES=8, DEPTH=16, STRIDE=5, OFF_STEP=2)
// against a per-lane address model of the interleaving rule.
`timescale 1ns/1ps
module tb_interleaver_bus_n;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       CRC_start;
    logic       CRC_end;
    logic [1:0] mode;
    logic       out_ready;
    logic [7:0] data_out;
    logic       data_ready;
    logic       done;
    logic       busy;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] blk [16];
    logic [7:0] obs [16];

    always #5 clk = ~clk;

    interleaver_bus_n #(.LANES(8), .DEPTH(16), .STRIDE(5), .OFF_STEP(2)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .CRC_start(CRC_start),
        .CRC_end(CRC_end), .mode(mode), .out_ready(out_ready), .data_out(data_out),
        .data_ready(data_ready), .done(done), .busy(busy), .err(err)
    );

    // Output word i: lane k takes bit k of the block word at (5*i + off_k) mod 16,
    // where words at or beyond the block length read as zero padding.
    function automatic logic [7:0] exp_word(input int i, input int m, input int n);
        logic [7:0] r;
        int off;
        int a;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            case (m)
                1:       off = (k * 2) % 16;
                2:       off = (((8 - k) % 8) * 2) % 16;
                default: off = 0;
            endcase
            a = (i * 5 + off) % 16;
            if (a < n) r[k] = blk[a][k];
        end
        return r;
    endfunction

    task automatic feed(input int n, input logic [1:0] m, input bit no_wait, output int err_cnt);
        err_cnt = 0;
        for (int j = 0; j < n; j++) begin
            if (!(no_wait && j == 0)) @(negedge clk);
            if (err) err_cnt++;
            CRC_start = (j == 0);
            CRC_end   = (j == n - 1);
            data_in   = blk[j];
            mode      = m;
        end
        @(negedge clk);
        if (err) err_cnt++;
        CRC_start = 1'b0;
        CRC_end   = 1'b0;
        data_in   = 8'($urandom);
        mode      = 2'($urandom);
    endtask

    task automatic collect(input int ready_pct, input int stall_word, output int nobs,
                           output int lat, output int stall_bad, output int done_cnt,
                           output bit done_after, output bit tmo);
        logic [7:0] prev;
        bit prev_stall;
        int stall_cnt;
        nobs = 0; lat = -1; stall_bad = 0; done_cnt = 0; done_after = 0; tmo = 0;
        prev = '0; prev_stall = 0; stall_cnt = 0;
        for (int cyc = 0; cyc < 400 && nobs < 16; cyc++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (data_ready && lat < 0) lat = cyc;
            if (prev_stall && (!data_ready || data_out !== prev)) stall_bad++;
            if (data_ready && nobs == stall_word && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            prev_stall = data_ready && !out_ready;
            prev = data_out;
            if (data_ready && out_ready) begin
                obs[nobs] = data_out;
                nobs++;
            end
        end
        if (nobs < 16) begin
            tmo = 1;
        end else begin
            @(negedge clk);
            if (done) done_cnt++;
            done_after = (done === 1'b1) && (data_ready === 1'b0) && (busy === 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; data_in = '0; CRC_start = 0; CRC_end = 0; mode = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({data_out, data_ready, done, busy, err} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs got %h required 000", {data_out, data_ready, done, busy, err});
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy got %b required 0", busy);
        end
    endtask

    task automatic test_full_mode0();
        int ec, nobs, lat, sb, dc; bit da, tmo;
        for (int j = 0; j < 16; j++) blk[j] = 8'(j);
        feed(16, 2'd0, 0, ec);
        vectors++;
        if (data_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL full_gap ready/busy got %b%b required 01", data_ready, busy);
        end
        collect(100, -1, nobs, lat, sb, dc, da, tmo);
        vectors++;
        if (tmo || lat !== 0) begin
            miscompares++;
            $display("FAIL full_latency got %0d (timeout %0d) required 0", lat, tmo);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs[i] !== exp_word(i, 0, 16)) begin
                miscompares++;
                $display("FAIL full_word%0d got %h required %h", i, obs[i], exp_word(i, 0, 16));
            end
        end
        vectors++;
        if (obs[3] !== 8'h0F) begin
            miscompares++;
            $display("FAIL full_word3_literal got %h required 0f", obs[3]);
        end
        vectors++;
        if (!da || dc !== 1 || ec !== 0) begin
            miscompares++;
            $display("FAIL full_done done_after=%0d done_cnt=%0d err_cnt=%0d required 1,1,0", da, dc, ec);
        end
    endtask

    task automatic test_mode1();
        int ec, nobs, lat, sb, dc; bit da, tmo;
        for (int j = 0; j < 16; j++) blk[j] = 8'(j);
        feed(16, 2'd1, 0, ec);
        collect(100, -1, nobs, lat, sb, dc, da, tmo);
        vectors++;
        if (obs[0] !== 8'h06) begin
            miscompares++;
            $display("FAIL mode1_word0 got %h required 06", obs[0]);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs[i] !== exp_word(i, 1, 16)) begin
                miscompares++;
                $display("FAIL mode1_word%0d got %h required %h", i, obs[i], exp_word(i, 1, 16));
            end
        end
        vectors++;
        if (!da || dc !== 1 || tmo) begin
            miscompares++;
            $display("FAIL mode1_done done_after=%0d done_cnt=%0d required 1,1", da, dc);
        end
    endtask

    task automatic test_short_block();
        int ec, nobs, lat, sb, dc; bit da, tmo;
        for (int j = 0; j < 16; j++) blk[j] = (j < 4) ? 8'(j) : 8'hFF;
        feed(4, 2'd0, 0, ec);
        collect(100, -1, nobs, lat, sb, dc, da, tmo);
        vectors++;
        if (lat !== 12) begin
            miscompares++;
            $display("FAIL short_fill_latency got %0d required 12", lat);
        end
        vectors++;
        if (obs[1] !== 8'h00 || obs[13] !== 8'h01 || obs[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL short_literals got %h %h %h required 00 00 01", obs[0], obs[1], obs[13]);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs[i] !== exp_word(i, 0, 4)) begin
                miscompares++;
                $display("FAIL short_word%0d got %h required %h", i, obs[i], exp_word(i, 0, 4));
            end
        end
        vectors++;
        if (!da || dc !== 1 || tmo) begin
            miscompares++;
            $display("FAIL short_done done_after=%0d done_cnt=%0d required 1,1", da, dc);
        end
    endtask

    task automatic test_backpressure();
        int ec, nobs, lat, sb, dc; bit da, tmo;
        for (int j = 0; j < 16; j++) blk[j] = 8'(j);
        feed(16, 2'd0, 0, ec);
        collect(100, 2, nobs, lat, sb, dc, da, tmo);
        vectors++;
        if (sb !== 0) begin
            miscompares++;
            $display("FAIL stall_hold unstable cycles got %0d required 0", sb);
        end
        vectors++;
        if (obs[2] !== 8'h0A || obs[3] !== 8'h0F) begin
            miscompares++;
            $display("FAIL stall_words got %h %h required 0a 0f", obs[2], obs[3]);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs[i] !== exp_word(i, 0, 16)) begin
                miscompares++;
                $display("FAIL stall_word%0d got %h required %h", i, obs[i], exp_word(i, 0, 16));
            end
        end
    endtask

    task automatic test_mid_start();
        int ec, nobs, lat, sb, dc; bit da, tmo;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            CRC_start = (j == 0); CRC_end = 1'b0; data_in = 8'($urandom); mode = 2'd1;
        end
        for (int j = 0; j < 16; j++) blk[j] = 8'(j);
        feed(16, 2'd0, 0, ec);
        vectors++;
        if (ec !== 1) begin
            miscompares++;
            $display("FAIL midstart_err pulses got %0d required 1", ec);
        end
        collect(100, -1, nobs, lat, sb, dc, da, tmo);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs[i] !== exp_word(i, 0, 16)) begin
                miscompares++;
                $display("FAIL midstart_word%0d got %h required %h", i, obs[i], exp_word(i, 0, 16));
            end
        end
        vectors++;
        if (!da || dc !== 1 || tmo) begin
            miscompares++;
            $display("FAIL midstart_done done_after=%0d done_cnt=%0d required 1,1", da, dc);
        end
    endtask

    task automatic test_reset_mid_drain();
        int ec, n, dc, nobs, lat, sb; bit da, tmo;
        for (int j = 0; j < 16; j++) blk[j] = 8'(j);
        feed(16, 2'd0, 0, ec);
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 7; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (data_ready) n++;
        end
        @(negedge clk);
        vectors++;
        if (data_out !== exp_word(7, 0, 16)) begin
            miscompares++;
            $display("FAIL rstdrain_word7 got %h required %h", data_out, exp_word(7, 0, 16));
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({data_out, data_ready, busy, done} !== 11'h000) begin
            miscompares++;
            $display("FAIL rstdrain_async got %h required 000", {data_out, data_ready, busy, done});
        end
        dc = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        vectors++;
        if (dc !== 0) begin
            miscompares++;
            $display("FAIL rstdrain_no_done activity cycles got %0d required 0", dc);
        end
        for (int j = 0; j < 16; j++) blk[j] = 8'($urandom);
        feed(16, 2'd2, 0, ec);
        collect(100, -1, nobs, lat, sb, dc, da, tmo);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs[i] !== exp_word(i, 2, 16)) begin
                miscompares++;
                $display("FAIL rstdrain_next_word%0d got %h required %h", i, obs[i], exp_word(i, 2, 16));
            end
        end
    endtask

    task automatic test_back_to_back();
        int ec, nobs, lat, sb, dc, n, m; bit da, tmo;
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, 16);
            m = $urandom_range(0, 3);
            for (int j = 0; j < 16; j++) blk[j] = 8'($urandom);
            feed(n, 2'(m), (b > 0), ec);
            collect(65, -1, nobs, lat, sb, dc, da, tmo);
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (obs[i] !== exp_word(i, m, n)) begin
                    miscompares++;
                    $display("FAIL b2b%0d_word%0d got %h required %h (n=%0d mode=%0d)",
                             b, i, obs[i], exp_word(i, m, n), n, m);
                end
            end
            vectors++;
            if (!da || dc !== 1 || sb !== 0 || ec !== 0 || tmo) begin
                miscompares++;
                $display("FAIL b2b%0d_ctrl done_after=%0d done_cnt=%0d stall_bad=%0d err=%0d tmo=%0d required 1,1,0,0,0",
                         b, da, dc, sb, ec, tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_mode0();
        test_mode1();
        test_short_block();
        test_backpressure();
        test_mid_start();
        test_reset_mid_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interleaver_bus_n.md
# interleaver_bus_n

Parametrised successor to the fixed 8-lane bit-interleaver bus: accepts a block of `LANES`-bit words framed by `CRC_start`/`CRC_end`, buffers it, and replays it with a per-lane permuted read order. Short blocks are zero-padded to `DEPTH` words. Output uses a valid/ready handshake. Sits between the CRC attach stage and the rate-matching stage.

## Interface
- `LANES`, 8: bit lanes per word (≥2).
- `DEPTH`, 64: words per block; power of two, ≥4.
- `STRIDE`, 5: read stride; odd, <`DEPTH`.
- `OFF_STEP`, 2: per-lane offset step, <`DEPTH`.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears state and outputs, not buffer contents.
- `data_in` in `LANES`: input word, sampled every cycle in LOAD, and with `CRC_start` in IDLE.
- `CRC_start` in 1: first word of block.
- `CRC_end` in 1: last word of block.
- `mode` in 2: offset table, latched with `CRC_start`.
- `out_ready` in 1: downstream accepts `data_out`.
- `data_out` out `LANES`: interleaved word, registered.
- `data_ready` out 1: `data_out` valid.
- `done` out 1: one-cycle pulse after last word accepted.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: one-cycle pulse, `CRC_start` seen in LOAD.

## Operation
- One `DEPTH`×1 buffer per lane. Write address `wcnt` is shared.
- The read index `i` runs 0..`DEPTH`-1. Lane k reads address `(i*STRIDE + off_k) mod DEPTH`. The mod is a bit mask.
- `off_k` by latched mode:
  - 0: 0.
  - 1: `(k*OFF_STEP) mod DEPTH`.
  - 2: `(((LANES-k) mod LANES)*OFF_STEP) mod DEPTH`.
  - 3: treated as 0.
- Lane 0 offset is always 0.
- States:
  - IDLE: on `CRC_start`, write `data_in` to address 0, latch `mode`, set `wcnt`=1. If `CRC_end` is also high, go to FILL; otherwise go to LOAD.
  - LOAD: write `data_in` at `wcnt`, then increment `wcnt`. If `wcnt`=`DEPTH`-1, go to DRAIN (a `CRC_end` here is ignored). Else if `CRC_end`, go to FILL.
  - LOAD with `CRC_start`: `err`=1; write `data_in` at address 0, set `wcnt`=1, relatch `mode`, stay in LOAD. `CRC_start` takes priority over `CRC_end` in the same cycle.
  - FILL: write 0 at `wcnt`, then increment `wcnt`. At `wcnt`=`DEPTH`-1, go to DRAIN.
  - DRAIN: present word i. On `data_ready && out_ready`: if i<`DEPTH`-1, load word i+1; else `data_ready`=0, `done`=1, go to IDLE.
- `CRC_start`/`CRC_end`/`data_in` are ignored in FILL and DRAIN. The upstream must watch `busy`.
- `CRC_start` is accepted in the `done` cycle, because the state is already IDLE.
- Reset value of all outputs is 0. Reset mid-block discards the block, and no `done` is issued.

## Timing
- Edge E writes the last buffer word and enters DRAIN.
- Edge E+1 registers word 0; `data_ready` is high from E+1.
- Full block: `DEPTH` write cycles, then 1 gap cycle, then ≥`DEPTH` output cycles.
- Input is one word per cycle with no stall.
- `data_out` is held stable while `data_ready && !out_ready`.
- `done` is high in the cycle after the final handshake edge.
- `busy` is a decode of the state register.
- `err` is high for the cycle after the offending edge.

## Configuration
- `INTERLEAVER_BUS_DEBUG_EN` defined: adds outputs `dbg_state`[2:0], `dbg_wcnt`[log2 `DEPTH`] and `dbg_rcnt`[log2 `DEPTH`], driven from internal registers.
- State encoding: IDLE=0, LOAD=1, FILL=2, DRAIN=3.
- Macro undefined: these ports are absent; function is identical.

## Test plan
- `LANES`=8, `DEPTH`=16, `STRIDE`=5, `OFF_STEP`=2, input word j = j (j=0..15), `mode`=0, `CRC_end` on j=15, `out_ready`=1. Required:
  - `data_out` sequence 0x00,0x05,0x0A,0x0F,0x04,….
  - `data_ready` rises 1 cycle after the last write.
  - `done` pulses after 16 words.
- Same stimulus with `mode`=1 → word 0 = 0x06 (lane k reads address 2k).
- `mode`=0, `CRC_end` on j=3 (words 0..3) → 12 FILL cycles, then:
  - word 1 (addr 5) = 0x00.
  - word 13 (addr 1) = 0x01.
  - word 0 = 0x00.
- Hold `out_ready`=0 for 3 cycles at word 2 → `data_out`=0x0A stays stable, `data_ready`=1, no word is skipped.
- Mid-block start: `CRC_start` at j=6 of LOAD → `err` pulses once; the block restarts at address 0 and output matches the first scenario for the new 16 words.
- Reset mid-DRAIN: assert `reset` at word 7 → outputs 0 asynchronously, no `done`; the next block runs normally.
